// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row sense in, column drive and key events out.
// master: keypad/consumer side; slave: the scanner itself.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_press;

  modport master (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_press
  );

  modport slave (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_press
  );
endinterface

// File: rtl/keypad_scanner.sv
// Column-scanning, debounced 4x4 keypad front end (player-B PMOD keypad).
// Drives one-cold columns, samples synchronized active-low rows at the end of
// each column dwell, resolves one key per full scan, and accepts a key state
// once it has been seen on DEBOUNCE_SCANS consecutive scans.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat key_press every
// REPEAT_SCANS scans while the accepted key is held).
module keypad_scanner #(
  parameter int COL_CYCLES     = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.slave  kp
);

  localparam int DCW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
  localparam int SCW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(COL_CYCLES - 1);
  localparam logic [SCW-1:0] SC_FULL = SCW'(DEBOUNCE_SCANS);

  // Parameter range checks at elaboration
  generate
    if (COL_CYCLES < 4) begin : g_bad_col_cycles
      $error("keypad_scanner: COL_CYCLES must be at least 4");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
      $error("keypad_scanner: DEBOUNCE_SCANS must be at least 1");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
      $error("keypad_scanner: REPEAT_SCANS must be at least 1");
    end
  endgenerate

  // Key map: index is {row, col}
  function automatic logic [3:0] f_keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = '0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      4'hF: k = 4'hD;
      default: k = '0;
    endcase
    return k;
  endfunction

  logic [3:0]     r_row_s1;
  logic [3:0]     r_row_s2;
  logic [DCW-1:0] r_dc;
  logic [1:0]     r_ci;
  logic           r_commit;
  logic           r_hit;
  logic [3:0]     r_code;
  logic           r_cand_hit;
  logic [3:0]     r_cand_code;
  logic [SCW-1:0] r_cnt;
  logic [3:0]     r_key_code;
  logic           r_key_valid;
  logic           r_key_press;

  logic           w_sample;
  logic           w_any_low;
  logic [1:0]     w_row_idx;
  logic           w_same;
  logic [SCW-1:0] w_cnt_next;
  logic           w_change;
  logic           w_rep_fire;

  // Two-flop synchronizer on the asynchronous row inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= kp.row;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_sample  = (r_dc == DC_LAST);
  assign w_any_low = (r_row_s2 != 4'hF);

  // Lowest-numbered low row wins within the driven column
  always_comb begin
    w_row_idx = '0;
    if (!r_row_s2[0])      w_row_idx = 2'd0;
    else if (!r_row_s2[1]) w_row_idx = 2'd1;
    else if (!r_row_s2[2]) w_row_idx = 2'd2;
    else if (!r_row_s2[3]) w_row_idx = 2'd3;
  end

  // Dwell counter and column index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dc <= '0;
      r_ci <= '0;
    end else if (w_sample) begin
      r_dc <= '0;
      r_ci <= r_ci + 2'd1;
    end else begin
      r_dc <= r_dc + 1'b1;
    end
  end

  assign kp.col = ~(4'b0001 << r_ci);

  // Per-scan result capture; first hit in scan order is kept, cleared at commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit <= 1'b0;
      r_hit    <= 1'b0;
      r_code   <= '0;
    end else begin
      r_commit <= w_sample && (r_ci == 2'd3);
      if (r_commit) begin
        r_hit  <= 1'b0;
        r_code <= '0;
      end else if (w_sample && !r_hit && w_any_low) begin
        r_hit  <= 1'b1;
        r_code <= f_keymap(w_row_idx, r_ci);
      end
    end
  end

  // Debounce comparison and acceptance decision for the commit cycle
  always_comb begin
    w_same     = (r_hit == r_cand_hit) && (!r_hit || (r_code == r_cand_code));
    w_cnt_next = SCW'(1);
    if (w_same) begin
      w_cnt_next = (r_cnt == SC_FULL) ? r_cnt : r_cnt + 1'b1;
    end
    w_change = (w_cnt_next == SC_FULL) &&
               ((r_hit != r_key_valid) || (r_hit && (r_code != r_key_code)));
  end

  // Candidate state and stable-scan count, updated once per scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cand_hit  <= 1'b0;
      r_cand_code <= '0;
      r_cnt       <= '0;
    end else if (r_commit) begin
      r_cand_hit  <= r_hit;
      r_cand_code <= r_code;
      r_cnt       <= w_cnt_next;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_SCANS - 1);

  logic [RPW-1:0] r_rep;

  assign w_rep_fire = r_commit && r_key_valid && !w_change && (r_rep == RP_LAST);

  // Auto-repeat scan counter; restarts whenever the accepted state changes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep <= '0;
    end else if (r_commit) begin
      if (w_change || !r_key_valid || w_rep_fire) begin
        r_rep <= '0;
      end else begin
        r_rep <= r_rep + 1'b1;
      end
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Registered accepted-key outputs and press pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_press <= 1'b0;
    end else begin
      r_key_press <= 1'b0;
      if (r_commit && w_change) begin
        r_key_valid <= r_hit;
        if (r_hit) begin
          r_key_code  <= r_code;
          r_key_press <= 1'b1;
        end
      end else if (w_rep_fire) begin
        r_key_press <= 1'b1;
      end
    end
  end

  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_press = r_key_press;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed steps plus a randomized
// scan-by-scan phase checked against a per-scan keypad/debounce model.
module tb_keypad_scanner;
  localparam int C    = 8;
  localparam int D    = 3;
  localparam int R    = 4;
  localparam int SCAN = 4 * C;
  localparam int LAY [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad = 0;
  int press_seen = 0;
  logic prev_press = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner_if kp_if ();

  keypad_scanner #(.COL_CYCLES(C), .DEBOUNCE_SCANS(D), .REPEAT_SCANS(R)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  // Keypad model: a pressed key pulls its row low while its column is driven
  always_comb begin
    kp_if.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[LAY[r][c]] && !kp_if.col[c]) kp_if.row[r] = 1'b0;
  end

  // Count presses and require that no two are back to back
  always @(negedge clk) begin
    if (kp_if.key_press === 1'b1) begin
      press_seen++;
      total++;
      assert (prev_press === 1'b0) else begin
        bad++;
        $error("FAIL press_consec observed=%b expected=0", prev_press);
      end
    end
    prev_press = kp_if.key_press;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Move to the first cycle of a scan (column 0 just started)
  task automatic align();
    logic [3:0] p;
    bit ok;
    ok = 0;
    p = kp_if.col;
    for (int i = 0; i < 2 * SCAN; i++) begin
      tick(1);
      if (kp_if.col == 4'b1110 && p == 4'b0111) begin
        ok = 1;
        break;
      end
      p = kp_if.col;
    end
    chk("align", 32'(ok), 32'd1);
  endtask

  // Wait for key_press with a bound; returns latency in clocks (0 = timeout)
  task automatic wait_press(output int lat);
    lat = 0;
    for (int i = 1; i <= 4 * SCAN; i++) begin
      tick(1);
      if (kp_if.key_press === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic int scan_res(input logic [15:0] m);
    int best;
    best = -1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[LAY[r][c]] && best < 0) best = LAY[r][c];
    return best;
  endfunction

  initial begin
    int lat, p0, drop;
    logic [3:0] e;
    int hist[$];
    int m_valid, m_code, m_total, m_rep, res, prev_res, hold_left, sel, exp_pulse;
    logic [15:0] mask;

    // Reset state
    #1;
    chk("rst_col", kp_if.col, 4'b1110);
    chk("rst_code", kp_if.key_code, 4'h0);
    chk("rst_valid", kp_if.key_valid, 1'b0);
    chk("rst_press", kp_if.key_press, 1'b0);
    tick(3);
    chk("rst_col_hold", kp_if.col, 4'b1110);
    @(negedge clk) rst = 1'b1;
    for (int p = 1; p <= 32; p++) begin
      tick(1);
      e = ~(4'b0001 << ((p / C) % 4));
      chk("col_step", kp_if.col, e);
    end

    // Hold '5'
    align();
    p0 = press_seen;
    pressed = 16'(1) << 5;
    wait_press(lat);
    chk("k5_seen", 32'(lat != 0), 32'd1);
    chk("k5_lat_hi", 32'(lat <= D * SCAN + 3), 32'd1);
    chk("k5_lat_lo", 32'(lat >= (D - 1) * SCAN + 3), 32'd1);
    chk("k5_code", kp_if.key_code, 4'h5);
    chk("k5_valid", kp_if.key_valid, 1'b1);
    tick(3 * SCAN);
    chk("k5_one_press", 32'(press_seen - p0), 32'd1);

    // Release '5'
    align();
    p0 = press_seen;
    pressed = '0;
    lat = 0;
    for (int i = 1; i <= 4 * SCAN; i++) begin
      tick(1);
      if (kp_if.key_valid === 1'b0) begin
        lat = i;
        break;
      end
    end
    chk("rel_seen", 32'(lat != 0), 32'd1);
    chk("rel_lat_hi", 32'(lat <= D * SCAN + 3), 32'd1);
    chk("rel_lat_lo", 32'(lat >= (D - 1) * SCAN + 3), 32'd1);
    chk("rel_code", kp_if.key_code, 4'h5);
    chk("rel_nopress", 32'(press_seen - p0), 32'd0);

    // Bounce: '8' on alternate scans
    align();
    p0 = press_seen;
    for (int s = 0; s < 12; s++) begin
      pressed = (s % 2 == 0) ? (16'(1) << 8) : '0;
      tick(SCAN);
    end
    pressed = '0;
    tick(SCAN);
    chk("bnc_nopress", 32'(press_seen - p0), 32'd0);
    chk("bnc_valid", kp_if.key_valid, 1'b0);
    chk("bnc_code", kp_if.key_code, 4'h5);

    // '1' and '6' together, then release '1'
    align();
    pressed = (16'(1) << 1) | (16'(1) << 6);
    wait_press(lat);
    chk("k16_seen", 32'(lat != 0), 32'd1);
    chk("k16_code", kp_if.key_code, 4'h1);
    align();
    p0 = press_seen;
    pressed = 16'(1) << 6;
    drop = 0;
    for (int i = 0; i < D * SCAN + 8; i++) begin
      tick(1);
      if (kp_if.key_valid !== 1'b1) drop = 1;
    end
    chk("k6_nodrop", 32'(drop), 32'd0);
    chk("k6_code", kp_if.key_code, 4'h6);
    chk("k6_one_press", 32'(press_seen - p0), 32'd1);

    // Reset mid-scan with '9' held
    align();
    pressed = 16'(1) << 9;
    tick(4 * SCAN);
    chk("k9_pre_code", kp_if.key_code, 4'h9);
    chk("k9_pre_valid", kp_if.key_valid, 1'b1);
    tick(2 * C + 3);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", kp_if.key_valid, 1'b0);
    chk("mrst_code", kp_if.key_code, 4'h0);
    chk("mrst_press", kp_if.key_press, 1'b0);
    chk("mrst_col", kp_if.col, 4'b1110);
    tick(3);
    @(negedge clk) rst = 1'b1;
    lat = 0;
    for (int i = 1; i <= 4 * SCAN; i++) begin
      @(posedge clk);
      #1;
      if (kp_if.key_press === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("k9_re_seen", 32'(lat != 0), 32'd1);
    chk("k9_re_lat_hi", 32'(lat <= D * SCAN + 3), 32'd1);
    chk("k9_re_lat_lo", 32'(lat >= (D - 1) * SCAN + 3), 32'd1);
    chk("k9_re_code", kp_if.key_code, 4'h9);

`ifdef KEYPAD_REPEAT_EN
    // Hold 'A' for 20 scans: one acceptance pulse plus repeats every R scans
    align();
    p0 = press_seen;
    pressed = 16'(1) << 10;
    tick(20 * SCAN);
    pressed = '0;
    tick(4 * SCAN);
    chk("rep_count", 32'(press_seen - p0), 32'd5);
`endif

    // Randomized per-scan phase against the model
    pressed = '0;
    align();
    tick(4 * SCAN);
    m_valid = 0;
    m_code = kp_if.key_code;
    m_total = press_seen;
    m_rep = 0;
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back(-1);
    prev_res = -1;
    hold_left = 0;
    mask = '0;
    for (int s = 0; s < 48; s++) begin
      if (hold_left == 0) begin
        sel = $urandom_range(0, 9);
        mask = '0;
        if (sel >= 3) mask[$urandom_range(0, 15)] = 1'b1;
        if (sel >= 8) mask[$urandom_range(0, 15)] = 1'b1;
        hold_left = $urandom_range(1, 5);
      end
      hold_left--;
      pressed = mask;
      res = scan_res(mask);
      // Model: commit of the scan that just ended
      hist.push_back(prev_res);
      void'(hist.pop_front());
      exp_pulse = 0;
      if (hist[0] == hist[1] && hist[1] == hist[D - 1] &&
          ((hist[0] < 0) ? (m_valid == 1) : (m_valid == 0 || m_code != hist[0]))) begin
        m_rep = 0;
        if (hist[0] < 0) m_valid = 0;
        else begin
          m_valid = 1;
          m_code = hist[0];
          exp_pulse = 1;
        end
      end else if (m_valid == 1) begin
`ifdef KEYPAD_REPEAT_EN
        m_rep++;
        if (m_rep == R) begin
          m_rep = 0;
          exp_pulse = 1;
        end
`endif
      end
      m_total += exp_pulse;
      tick(1);
      chk("rnd_valid", kp_if.key_valid, 32'(m_valid));
      chk("rnd_code", kp_if.key_code, 32'(m_code));
      chk("rnd_press", kp_if.key_press, 32'(exp_pulse));
      tick(SCAN - 1);
      prev_res = res;
    end
    chk("rnd_total_press", 32'(press_seen), 32'(m_total));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Column-scanning, debounced front end for the player-B PMOD keypad. It drives the four column lines, samples the four row lines, and resolves one stable key per scan. It emits a 4-bit hex key code with a level-valid and a one-cycle press pulse. It sits directly upstream of `chara_control` and supplies its player-B input, replacing the raw row-only decode.

## Interface
- `COL_CYCLES`, default 100000: clocks each column is driven; minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a state; minimum 1.
- `REPEAT_SCANS`, default 64: auto-repeat interval in scans; used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `row`  in  4  keypad rows, active-low and pulled up; `row[0]` is the top row.
- `col`  out  4  column drive, one-cold; `col[0]` is the leftmost column.
- `key_code`  out  4  accepted key, as a hex value.
- `key_valid`  out  1  high while an accepted key is held.
- `key_press`  out  1  one-cycle pulse for each newly accepted key.

## Operation
- Key map, rows top to bottom, columns 0 to 3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- `row` passes through a 2-flop synchronizer before any use.
- Dwell counter `dc` counts 0..`COL_CYCLES`-1. Column index `ci` advances 0→1→2→3→0 when `dc` wraps. `col` = ~(1<<`ci`).
- SAMPLE: on the cycle where `dc`=`COL_CYCLES`-1, the synchronized rows are examined.
  - The first low row in the lowest column wins; lowest row index breaks ties within a column.
  - Later hits in the same scan are ignored.
- COMMIT: on the cycle after the column-3 sample, the scan result (hit + code, or none) is compared with the candidate.
  - Equal: the stable count increments, saturating at `DEBOUNCE_SCANS`.
  - Different: candidate = result and count = 1.
  - Scan-result registers then clear.
- Acceptance: when the count reaches `DEBOUNCE_SCANS` and the candidate differs from the accepted state, the accepted state is replaced.
  - None → key K: `key_code`=K, `key_valid`=1, `key_press` pulses.
  - Key J → key K, with K≠J: `key_code`=K, `key_press` pulses, `key_valid` stays 1.
  - Key → none: `key_valid`=0, `key_code` holds its last value, no pulse.
- At most one `key_press` per scan. `key_press` is never high on two consecutive cycles.

## Timing
- Reset values: `col`=4'b1110, `ci`=0, `dc`=0, `key_code`=0, `key_valid`=0, `key_press`=0. Candidate = none, count = 0, repeat counter = 0.
- Reset is asynchronous and can arrive mid-scan. The partial scan is discarded; scanning restarts at column 0, `dc`=0, on the first clock after release.
- Scan period = 4×`COL_CYCLES` clocks.
- Outputs are registered and update on the clock edge after COMMIT.
- Press-to-`key_press` latency for a clean press: between (`DEBOUNCE_SCANS`−1)×4×`COL_CYCLES`+3 and `DEBOUNCE_SCANS`×4×`COL_CYCLES`+3 clocks.
- Release latency has the same bounds.
- A row change after SAMPLE, within the same dwell, is not seen until that column's next dwell.

## Configuration
- `KEYPAD_REPEAT_EN` defined: while `key_valid`=1 and the accepted key is unchanged, a repeat counter increments at each COMMIT.
  - Each time it reaches `REPEAT_SCANS`, `key_press` pulses and the counter clears.
  - The counter clears on any acceptance change.
- `KEYPAD_REPEAT_EN` undefined: exactly one `key_press` per accepted key; the repeat logic is absent.

## Test plan
Bench parameters: `COL_CYCLES`=8, `DEBOUNCE_SCANS`=3, `REPEAT_SCANS`=4. The keypad model pulls row r low only while the pressed key's column is driven low.
- Reset: `rst`=0 → `col`=1110 and all outputs 0. Release → `col` steps 1110, 1101, 1011, 0111 every 8 clocks.
- Hold '5' (row 1, column 1) → within 96+3 clocks `key_code`=5 and `key_valid`=1, with exactly one `key_press` (non-repeat build).
- Bounce: '8' present on alternate scans for 12 scans → no `key_press`, `key_valid`=0.
- Press '1' and '6' together → `key_code`=1. Then release '1' → after 3 scans `key_code`=6 with one `key_press`, and `key_valid` never drops.
- Release after '5' → `key_valid`=0 within 3 scans+3 clocks, `key_code` stays 5. With `KEYPAD_REPEAT_EN`, hold 'A' for 20 scans → pulses at acceptance and then every 4 scans (5 total, or 4 if fewer than 16 scans remain after acceptance).
- Assert `rst` during column 2 with '9' held → outputs clear immediately; after release, '9' is re-accepted after 3 full scans.
